// File: rtl/uart_tx_param_if.sv
// Controller-side handshake and line signals of the parametrised UART transmitter.
// The controller uses the master modport; the transmitter uses the slave modport.
interface uart_tx_param_if #(
  parameter int DATA_W = 8
);
  logic              STT;
  logic [DATA_W-1:0] DIN;
  logic              TX;
  logic              EOT;
  logic              DONE;
  logic [2:0]        STATE;

  modport master (output STT, DIN, input TX, EOT, DONE, STATE);
  modport slave  (input STT, DIN, output TX, EOT, DONE, STATE);
endinterface

// File: rtl/uart_tx_param.sv
// Parametrised RS232 transmitter: baud divider, LSB-first shift register,
// optional odd/even parity and one or two stop bits behind an STT/EOT handshake.
module uart_tx_param #(
  parameter int CLKS_PER_BIT = 434,
  parameter int DATA_W       = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic            CLK,
  input  logic            RST,
  uart_tx_param_if.slave  bus
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = $clog2(DATA_W + 1);

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] DATA_LAST = IDX_W'(DATA_W - 1);
  localparam logic [IDX_W-1:0] STOP_LAST = IDX_W'(STOP_BITS - 1);
  localparam bit               PAR_EN    = (PARITY != 0);
  localparam bit               PAR_ODD   = (PARITY == 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    PAR   = 3'd3,
    STOP  = 3'd4
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic              par_q, par_d;
  logic              tx_q, tx_d;
  logic              eot_q, eot_d;
  logic              done_q, done_d;
  logic              last_cnt;

  assign last_cnt = (cnt_q == CNT_LAST);

  always_comb begin
    // NOTE: every variable gets a default before the case so no path can infer a latch.
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    shift_d  = shift_q;
    par_d    = par_q;
    tx_d     = tx_q;
    done_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        tx_d  = 1'b1;
        cnt_d = '0;
        idx_d = '0;
        if (bus.STT) begin
          shift_d = bus.DIN;
          par_d   = PAR_ODD ? ~^bus.DIN : ^bus.DIN;
          tx_d    = 1'b0;
          state_d = START;
        end
      end

      START: begin
        if (last_cnt) begin
          cnt_d   = '0;
          idx_d   = '0;
          tx_d    = shift_q[0];
          shift_d = shift_q >> 1;
          state_d = DATA;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      DATA: begin
        if (last_cnt) begin
          cnt_d = '0;
          if (idx_q == DATA_LAST) begin
            idx_d = '0;
            if (PAR_EN) begin
              tx_d    = par_q;
              state_d = PAR;
            end else begin
              tx_d    = 1'b1;
              state_d = STOP;
            end
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            tx_d    = shift_q[0];
            shift_d = shift_q >> 1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      PAR: begin
        if (last_cnt) begin
          cnt_d   = '0;
          idx_d   = '0;
          tx_d    = 1'b1;
          state_d = STOP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      STOP: begin
        if (last_cnt) begin
          cnt_d = '0;
          // The stop bit index reuses the data bit index counter.
          if (idx_q == STOP_LAST) begin
            idx_d   = '0;
            tx_d    = 1'b1;
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: begin
        cnt_d   = '0;
        idx_d   = '0;
        tx_d    = 1'b1;
        state_d = IDLE;
      end
    endcase

    eot_d = (state_d == IDLE);
  end

  // NOTE: sequential state uses non-blocking assignments so all flops sample together.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      // NOTE: the shift register is reset too, so a fresh frame never exposes stale data.
      shift_q <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      eot_q   <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
      eot_q   <= eot_d;
      done_q  <= done_d;
    end
  end

  assign bus.TX    = tx_q;
  assign bus.EOT   = eot_q;
  assign bus.DONE  = done_q;
  assign bus.STATE = state_q;

endmodule
